// File: rtl/ddr2_wr_rd_seq_if.sv
// ddr2_wr_rd_seq_if: single-request stb/ack port between the write/read-verify
// sequencer (master) and the DDR2 controller wrapper (slave).
//
// Handshake: the master raises stb_o with we_o/addr_o/data_o and holds all
// four unchanged until the slave pulses ack_i for exactly one cycle. A new
// request may be presented on the edge that consumes the ack_i
// (back-to-back). rdata_i is valid only in the ack_i cycle of a read.
// An ack_i while stb_o is low carries no meaning and is ignored.
interface ddr2_wr_rd_seq_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 27
);
  logic              stb_o;
  logic              we_o;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] data_o;
  logic              ack_i;
  logic [DATA_W-1:0] rdata_i;

  modport master (
    output stb_o, we_o, addr_o, data_o,
    input  ack_i, rdata_i
  );

  modport slave (
    input  stb_o, we_o, addr_o, data_o,
    output ack_i, rdata_i
  );
endinterface

// File: rtl/ddr2_wr_rd_seq.sv
// ddr2_wr_rd_seq: writes NUM_WORDS pattern words to consecutive addresses over
// the stb/ack port, then reads them back and compares against the pattern.
// Reports pass/fail, a saturating mismatch count, the first failing address
// and a per-request watchdog timeout.
//
// Optional feature: define DDR2_SEQ_STOP_ON_ERR_EN to end the run at the
// first read mismatch. Without it every word is read and every mismatch is
// counted.
//
// dbg_state_o exposes the FSM state (0 IDLE, 1 WRITE, 2 READ, 3 DONE).
module ddr2_wr_rd_seq #(
  parameter int          DATA_W    = 128,
  parameter int          ADDR_W    = 27,
  parameter int          NUM_WORDS = 3,
  parameter int          BASE_ADDR = 0,
  parameter int          ADDR_STEP = 8,
  parameter logic [31:0] SEED      = 32'hF7D5FC30,
  parameter int          TIMEOUT   = 4096,
  parameter int          ERR_W     = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic [1:0]        dbg_state_o,
  ddr2_wr_rd_seq_if.master  bus
);

  localparam int LANES = DATA_W / 32;
  localparam int K_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [K_W-1:0]  K_LAST  = K_W'(NUM_WORDS - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [31:0]     GOLDEN  = 32'h9E3779B9;

`ifdef DDR2_SEQ_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [K_W-1:0]  k_q;
  logic [WD_W-1:0] wd_q;
  logic            wr_only_q;   // run was started in mode 01: no read phase

  // Address of word k; wraps silently at ADDR_W bits.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [K_W-1:0] k);
    return ADDR_W'(64'(BASE_ADDR) + 64'(k) * 64'(ADDR_STEP));
  endfunction

  // Pattern of word k: each 32-bit lane j carries p_k ^ j.
  function automatic logic [DATA_W-1:0] word_pat(input logic [K_W-1:0] k);
    logic [31:0]       p;
    logic [DATA_W-1:0] w;
    p = SEED + 32'(k) * GOLDEN;
    w = '0;
    for (int j = 0; j < LANES; j++) w[32*j +: 32] = p ^ 32'(j);
    return w;
  endfunction

  logic [K_W-1:0]   k_nxt;
  logic             last_word;
  logic             mismatch;
  logic             wd_hit;
  logic [ERR_W-1:0] err_nxt;

  // Next-word index, compare result and saturating error count for this cycle.
  always_comb begin
    k_nxt     = k_q + K_W'(1);
    last_word = (k_q == K_LAST);
    mismatch  = (bus.rdata_i != word_pat(k_q));
    wd_hit    = (wd_q == WD_LAST);
    err_nxt   = err_cnt_o;
    if (mismatch && (err_cnt_o != '1)) err_nxt = err_cnt_o + ERR_W'(1);
  end

  assign dbg_state_o = state;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state            <= S_IDLE;
      k_q              <= '0;
      wd_q             <= '0;
      wr_only_q        <= 1'b0;
      bus.stb_o        <= 1'b0;
      bus.we_o         <= 1'b0;
      bus.addr_o       <= '0;
      bus.data_o       <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      timeout_o        <= 1'b0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            k_q              <= '0;
            wd_q             <= '0;
            err_cnt_o        <= '0;
            first_err_addr_o <= '0;
            timeout_o        <= 1'b0;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            busy_o           <= 1'b1;
            bus.stb_o        <= 1'b1;
            bus.addr_o       <= word_addr('0);
            bus.data_o       <= word_pat('0);
            wr_only_q        <= (mode_i == 2'b01);
            if (mode_i == 2'b10) begin
              state    <= S_READ;
              bus.we_o <= 1'b0;
            end else begin
              state    <= S_WRITE;
              bus.we_o <= 1'b1;
            end
          end
        end

        S_WRITE, S_READ: begin
          if (!bus.ack_i) begin
            // Watchdog: request outstanding too long, abandon the run.
            if (wd_hit) begin
              state     <= S_DONE;
              wd_q      <= '0;
              bus.stb_o <= 1'b0;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
              pass_o    <= 1'b0;
              timeout_o <= 1'b1;
            end else begin
              wd_q <= wd_q + WD_W'(1);
            end
          end else if (state == S_WRITE) begin
            wd_q <= '0;
            if (last_word) begin
              if (wr_only_q) begin
                state     <= S_DONE;
                bus.stb_o <= 1'b0;
                busy_o    <= 1'b0;
                done_o    <= 1'b1;
                pass_o    <= 1'b1;
              end else begin
                state      <= S_READ;
                k_q        <= '0;
                bus.we_o   <= 1'b0;
                bus.addr_o <= word_addr('0);
                bus.data_o <= word_pat('0);
              end
            end else begin
              k_q        <= k_nxt;
              bus.addr_o <= word_addr(k_nxt);
              bus.data_o <= word_pat(k_nxt);
            end
          end else begin
            wd_q      <= '0;
            err_cnt_o <= err_nxt;
            if (mismatch && (err_cnt_o == '0)) first_err_addr_o <= bus.addr_o;
            if (last_word || (STOP_ON_ERR && mismatch)) begin
              state     <= S_DONE;
              bus.stb_o <= 1'b0;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
              pass_o    <= (err_nxt == '0);
            end else begin
              k_q        <= k_nxt;
              bus.addr_o <= word_addr(k_nxt);
              bus.data_o <= word_pat(k_nxt);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr2_wr_rd_seq.sv
// tb_ddr2_wr_rd_seq: two sequencer instances (default parameters, and a
// 4-word wrapping / short-watchdog variant) each driving a behavioural
// memory model. Expected transactions and results come from the pattern and
// address rules evaluated directly in the bench.
module tb_ddr2_wr_rd_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT connections ----------------
  logic [1:0]  start, busy, done, pass, tmo;
  logic [1:0]  mode [2];
  logic [15:0] err_cnt [2];
  logic [26:0] first_err [2];
  logic [1:0]  dbg_state [2];

  ddr2_wr_rd_seq_if #(.DATA_W(128), .ADDR_W(27)) bus [2] ();

  ddr2_wr_rd_seq u_dut0 (
    .clk_in(clk), .rst(rst), .start_i(start[0]), .mode_i(mode[0]),
    .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]), .timeout_o(tmo[0]),
    .err_cnt_o(err_cnt[0]), .first_err_addr_o(first_err[0]),
    .dbg_state_o(dbg_state[0]), .bus(bus[0])
  );

  ddr2_wr_rd_seq #(.NUM_WORDS(4), .BASE_ADDR(32'h07FFFFF0), .TIMEOUT(16)) u_dut1 (
    .clk_in(clk), .rst(rst), .start_i(start[1]), .mode_i(mode[1]),
    .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]), .timeout_o(tmo[1]),
    .err_cnt_o(err_cnt[1]), .first_err_addr_o(first_err[1]),
    .dbg_state_o(dbg_state[1]), .bus(bus[1])
  );

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int errors  = 0;
  logic [155:0] exp_q[$];   // {we, addr, write data or 0}
  logic [155:0] obs_q[$];
  logic [127:0] mem [logic [27:0]];

  logic [1:0]   stb_w, we_w;
  logic [26:0]  addr_w [2];
  logic [127:0] data_w [2];

  int          ack_dly [2];
  bit          rand_dly [2];
  bit          never_ack [2];
  bit          corrupt_en [2];
  logic [26:0] corrupt_addr [2];
  bit          stray_ack [2];
  time         last_ack_t [2];

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference pattern: lane j of word k = (SEED + k*golden) ^ j.
  function automatic logic [127:0] pat(input int k);
    logic [31:0]  p;
    logic [127:0] w;
    p = 32'hF7D5FC30 + 32'(k) * 32'h9E3779B9;
    for (int j = 0; j < 4; j++) w[32*j +: 32] = p ^ 32'(j);
    return w;
  endfunction

  // ---------------- memory models ----------------
  for (genvar g = 0; g < 2; g++) begin : g_mem
    int           cnt;
    int           cur_dly;
    bit           held;
    logic [155:0] held_req;

    assign stb_w[g]  = bus[g].stb_o;
    assign we_w[g]   = bus[g].we_o;
    assign addr_w[g] = bus[g].addr_o;
    assign data_w[g] = bus[g].data_o;

    // Acks each request after a delay; stores writes, returns (optionally
    // corrupted) read data, logs completed requests, checks request stability.
    always @(negedge clk) begin
      logic [155:0] req;
      logic [27:0]  key;
      logic [127:0] rd;
      req = {bus[g].we_o, bus[g].addr_o, bus[g].data_o};
      key = {1'(g), bus[g].addr_o};
      if (rst) begin
        bus[g].ack_i   = 1'b0;
        bus[g].rdata_i = '0;
        cnt = 0; held = 0;
      end else begin
        if (held && bus[g].stb_o) check("req_stable", req, held_req);
        bus[g].rdata_i = {$urandom, $urandom, $urandom, $urandom};
        if (bus[g].ack_i) begin
          bus[g].ack_i = 1'b0;
          cnt = 0; held = 0;
        end else if (stray_ack[g]) begin
          bus[g].ack_i = 1'b1;
          stray_ack[g] = 0;
          held = 0;
        end else if (bus[g].stb_o && !never_ack[g]) begin
          if (cnt == 0) cur_dly = rand_dly[g] ? int'($urandom_range(0, 4)) : ack_dly[g];
          if (cnt >= cur_dly) begin
            bus[g].ack_i = 1'b1;
            last_ack_t[g] = $time;
            held = 0;
            if (bus[g].we_o) begin
              mem[key] = bus[g].data_o;
              obs_q.push_back(req);
            end else begin
              rd = mem.exists(key) ? mem[key] : '0;
              if (corrupt_en[g] && bus[g].addr_o == corrupt_addr[g]) rd = rd ^ 128'h20;
              bus[g].rdata_i = rd;
              obs_q.push_back({1'b0, bus[g].addr_o, 128'h0});
            end
          end else begin
            cnt++;
            held = 1; held_req = req;
          end
        end else if (bus[g].stb_o) begin
          held = 1; held_req = req;
        end else begin
          cnt = 0; held = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset(input int g);
    check("rst_stb",   stb_w[g], 0);
    check("rst_we",    we_w[g], 0);
    check("rst_addr",  addr_w[g], 0);
    check("rst_data",  data_w[g], 0);
    check("rst_busy",  busy[g], 0);
    check("rst_done",  done[g], 0);
    check("rst_pass",  pass[g], 0);
    check("rst_tmo",   tmo[g], 0);
    check("rst_err",   err_cnt[g], 0);
    check("rst_first", first_err[g], 0);
    check("rst_state", dbg_state[g], 0);
  endtask

  // One run on instance g in mode md; expectations derived from the rules.
  task automatic run(input int g, input logic [1:0] md, input bit exp_to);
    int          nw;
    logic [26:0] base, a;
    int          exp_err;
    logic [26:0] exp_first;
    bit          good, stopped;
    int          cyc;
    time         t_rise;
    nw   = (g == 1) ? 4 : 3;
    base = (g == 1) ? 27'h7FFFFF0 : 27'h0;
    exp_q.delete();
    exp_err = 0; exp_first = '0; stopped = 0;
    if (!exp_to && md != 2'b10)
      for (int k = 0; k < nw; k++) exp_q.push_back({1'b1, base + 27'(k * 8), pat(k)});
    if (!exp_to && md != 2'b01)
      for (int k = 0; k < nw && !stopped; k++) begin
        a = base + 27'(k * 8);
        exp_q.push_back({1'b0, a, 128'h0});
        if (md == 2'b10) good = mem.exists({1'(g), a}) && (mem[{1'(g), a}] === pat(k));
        else good = 1;
        if (corrupt_en[g] && a == corrupt_addr[g]) good = 0;
        if (!good) begin
          if (exp_err == 0) exp_first = a;
          exp_err++;
`ifdef DDR2_SEQ_STOP_ON_ERR_EN
          stopped = 1;
`endif
        end
      end

    obs_q.delete();
    start[g] = 1'b1; mode[g] = md;
    step();
    start[g] = 1'b0;
    check("start_stb",  stb_w[g], 1);
    check("start_busy", busy[g], 1);
    check("start_we",   we_w[g], (md != 2'b10));
    check("start_addr", addr_w[g], base);
    if (md != 2'b10) check("start_data", data_w[g], pat(0));
    t_rise = $time;
    for (cyc = 0; cyc < 300 && !done[g]; cyc++) begin
      start[g] = busy[g] && ($urandom_range(0, 7) == 0);
      mode[g]  = 2'($urandom_range(0, 3));
      step();
    end
    start[g] = 1'b0;
    check("done",     done[g], 1);
    check("end_busy", busy[g], 0);
    check("end_stb",  stb_w[g], 0);
    if (exp_to) check("tmo_len", $time - t_rise, 160);
    else        check("done_lat", $time - last_ack_t[g], 11);
    check("pass",  pass[g], (!exp_to && exp_err == 0));
    check("tmo",   tmo[g], exp_to);
    check("err",   err_cnt[g], exp_err);
    check("first", first_err[g], exp_first);
    check("n_req", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) check("req", obs_q[i], exp_q[i]);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [155:0] e;
    int           cyc;
    int           rg;
    logic [1:0]   rmd;
    rst = 1'b1; start = '0; mode[0] = 2'b00; mode[1] = 2'b00;
    for (int g = 0; g < 2; g++) begin
      ack_dly[g] = 3; rand_dly[g] = 0; never_ack[g] = 0;
      corrupt_en[g] = 0; corrupt_addr[g] = '0; stray_ack[g] = 0; last_ack_t[g] = 0;
    end
    repeat (3) step();
    check_reset(0);
    check_reset(1);
    rst = 1'b0;
    step();

    // Write then verify, fixed 3-cycle ack latency.
    run(0, 2'b00, 0);
    e = (obs_q.size() > 0) ? obs_q[0] : '0;
    check("w0_lane0", e[31:0], 32'hF7D5FC30);
    e = (obs_q.size() > 2) ? obs_q[2] : '0;
    check("w2_addr", e[154:128], 27'h10);

    // Bit 5 corrupted on the read of 0x8.
    corrupt_en[0] = 1; corrupt_addr[0] = 27'h8;
    run(0, 2'b00, 0);
    corrupt_en[0] = 0;

    // Write only, then verify only.
    run(0, 2'b01, 0);
    run(0, 2'b10, 0);

    // Ack while idle in DONE changes nothing.
    stray_ack[0] = 1;
    step(); step();
    check("stray_done", done[0], 1);
    check("stray_busy", busy[0], 0);
    check("stray_stb",  stb_w[0], 0);
    check("stray_pass", pass[0], 1);

    // Mode 11 behaves as write then verify.
    run(0, 2'b11, 0);

    // Address wrap at 2^27.
    run(1, 2'b00, 0);
    e = (obs_q.size() > 2) ? obs_q[2] : '0;
    check("wrap_addr2", e[154:128], 27'h0);

    // Watchdog with a memory that never acks.
    never_ack[1] = 1;
    run(1, 2'b00, 1);
    never_ack[1] = 0;
    run(1, 2'b00, 0);

    // Reset during the second write's ack wait.
    ack_dly[0] = 5;
    obs_q.delete();
    start[0] = 1'b1; mode[0] = 2'b00;
    step();
    start[0] = 1'b0;
    for (cyc = 0; cyc < 100 && obs_q.size() < 1; cyc++) step();
    check("rst_run_first_ack", obs_q.size(), 1);
    step(); step();
    check("rst_run_wait_stb",  stb_w[0], 1);
    check("rst_run_wait_addr", addr_w[0], 27'h8);
    rst = 1'b1;
    step();
    check_reset(0);
    rst = 1'b0;
    step();
    run(0, 2'b00, 0);

    // Randomised runs: instance, mode, ack latency, optional corrupted word.
    for (int r = 0; r < 12; r++) begin
      rg  = int'($urandom_range(0, 1));
      rmd = 2'($urandom_range(0, 3));
      rand_dly[rg]     = 1;
      corrupt_en[rg]   = ($urandom_range(0, 1) == 1);
      corrupt_addr[rg] = ((rg == 1) ? 27'h7FFFFF0 : 27'h0)
                         + 27'(8 * $urandom_range(0, (rg == 1) ? 3 : 2));
      run(rg, rmd, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
